// File: rtl/config_pkg.sv
// config_pkg: shared types and constants for the TX scheduler
package config_pkg;
  typedef enum logic [1:0] {
    TS_IDLE = 2'd0,
    TS_ECHO = 2'd1,
    TS_RES  = 2'd2
  } tx_sched_state_t;
  localparam int RES_BYTES = 4;
endpackage

// File: rtl/word_to_bytes.sv
// word_to_bytes: holds a captured word and presents it one byte at a time, byte 0 first
module word_to_bytes #(
  parameter int RES_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [RES_W-1:0] word_i,
  input  logic             adv_i,
  output logic [7:0]       byte_o,
  output logic             last_o
);
  localparam int NB = RES_W / 8;
  localparam int CW = NB > 1 ? $clog2(NB) : 1;
  logic [RES_W-1:0] word_q;
  logic [CW-1:0]    cnt_q;
  // capture on load, step the byte index on each accepted byte, wrap after the last
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      word_q <= word_i;
      cnt_q  <= '0;
    end else if (adv_i) begin
      cnt_q  <= last_o ? '0 : cnt_q + 1'b1;
    end
  end
  assign byte_o = word_q[8*int'(cnt_q) +: 8];
  assign last_o = cnt_q == CW'(NB - 1);
endmodule

// File: rtl/tx_scheduler.sv
// tx_scheduler: per-packet round-robin share of the UART TX byte channel between echo and ALU results
import config_pkg::*;
module tx_scheduler #(
  parameter int RES_W = RES_BYTES * 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       echo_data_i,
  input  logic             echo_valid_i,
  input  logic             echo_last_i,
  output logic             echo_ready_o,
  input  logic [RES_W-1:0] res_data_i,
  input  logic             res_valid_i,
  output logic             res_ready_o,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic             busy_o,
  output logic [1:0]       state_o
);
  tx_sched_state_t state_q, state_d;
  logic rr_q, grant_echo, grant_res, load, adv, ser_last;
  logic [7:0] ser_byte;
  assign grant_echo = echo_valid_i && !(res_valid_i && rr_q);
  assign grant_res  = res_valid_i && !grant_echo;
  word_to_bytes #(.RES_W(RES_W)) u_ser (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .word_i (res_data_i),
    .adv_i  (adv),
    .byte_o (ser_byte),
    .last_o (ser_last)
  );
  // arbitration in IDLE, pass-through in ECHO, serializer drive in RES
  always_comb begin
    state_d      = state_q;
    tx_data_o    = '0;
    tx_valid_o   = 1'b0;
    echo_ready_o = 1'b0;
    res_ready_o  = 1'b0;
    load         = 1'b0;
    adv          = 1'b0;
    case (state_q)
      TS_IDLE: begin
        res_ready_o = grant_res;
        load        = grant_res;
        state_d     = grant_echo ? TS_ECHO : grant_res ? TS_RES : TS_IDLE;
      end
      TS_ECHO: begin
        tx_data_o    = echo_data_i;
        tx_valid_o   = echo_valid_i;
        echo_ready_o = tx_ready_i;
        state_d      = (echo_valid_i && tx_ready_i && echo_last_i) ? TS_IDLE : TS_ECHO;
      end
      TS_RES: begin
        tx_data_o  = ser_byte;
        tx_valid_o = 1'b1;
        adv        = tx_ready_i;
        state_d    = (tx_ready_i && ser_last) ? TS_IDLE : TS_RES;
      end
      default: state_d = TS_IDLE;
    endcase
  end
  // state register; finishing a packet hands priority to the other source
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TS_IDLE;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q != TS_IDLE && state_d == TS_IDLE) rr_q <= state_q == TS_ECHO;
    end
  end
  assign busy_o  = state_q != TS_IDLE;
  assign state_o = state_q;
endmodule
